// File: rtl/alu_seq16.sv
// 16-bit add/subtract sequenced over an external 8-bit ALU: low byte, high byte,
// then an optional carry/borrow fix-up pass on the high byte.
module alu_seq16 #(
  parameter logic [4:0] OP_ADD = 5'b01000,
  parameter logic [4:0] OP_SUB = 5'b01001,
  parameter logic [4:0] OP_NOP = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  output logic [4:0]  alu_opcode,
  input  logic [7:0]  alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        op_q, op_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        c0_q, c0_d;
  logic        c1_q, c1_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic [4:0]  passOpcode;
  logic        passCarry;

  // Carry/borrow comes from unsigned compares on the bytes we drive, not from ALU flags.
  assign passOpcode = op_q ? OP_SUB : OP_ADD;
  assign passCarry  = op_q ? (alu_operand1 < alu_operand2) : (alu_result < alu_operand1);

  always_comb begin
    alu_operand1 = 8'h00;
    alu_operand2 = 8'h00;
    alu_opcode   = OP_NOP;
    case (state_q)
      LO: begin
        alu_operand1 = a_q[7:0];
        alu_operand2 = b_q[7:0];
        alu_opcode   = passOpcode;
      end
      HI: begin
        alu_operand1 = a_q[15:8];
        alu_operand2 = b_q[15:8];
        alu_opcode   = passOpcode;
      end
      FIX: begin
        alu_operand1 = hi_q;
        alu_operand2 = 8'h01;
        alu_opcode   = passOpcode;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          state_d = LO;
        end
      end
      LO: begin
        lo_d    = alu_result;
        c0_d    = passCarry;
        state_d = HI;
      end
      HI: begin
        hi_d = alu_result;
        c1_d = passCarry;
        if (c0_q) begin
          state_d = FIX;
        end else begin
          zero_d  = ({alu_result, lo_q} == 16'h0000);
          carry_d = passCarry;
          state_d = DONE;
        end
      end
      FIX: begin
        hi_d    = alu_result;
        zero_d  = ({alu_result, lo_q} == 16'h0000);
        carry_d = c1_q | passCarry;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      op_q    <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = {hi_q, lo_q};
  assign rsp_zero   = zero_q;
  assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: an 8-bit ALU model, a 16-bit arithmetic reference model
// checked every cycle, and directed vectors with hand-computed results.
module tb_alu_seq16;

  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_NOP = 5'b00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_seq16 #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_NOP(OP_NOP)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // The external 8-bit ALU: purely combinational, no flags.
  always_comb begin
    alu_result = 8'h00;
    if (alu_opcode == OP_ADD) alu_result = alu_operand1 + alu_operand2;
    else if (alu_opcode == OP_SUB) alu_result = alu_operand1 - alu_operand2;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a request takes 3 cycles, or 4 when the low byte carries/borrows.
  bit          modelOn = 1'b0;
  bit          inFlight = 1'b0;
  bit          mDone = 1'b0;
  int          step = 0;
  int          lat = 0;
  logic [15:0] mA, mB;
  bit          mOp;
  bit          lowC;
  logic [7:0]  hiRaw;
  logic [15:0] expRes;
  bit          expZ, expC;

  always @(posedge clk) begin
    if (rst) begin
      inFlight = 1'b0;
      mDone    = 1'b0;
      modelOn  = 1'b1;
    end else if (mDone) begin
      if (rsp_ready) mDone = 1'b0;
    end else if (inFlight) begin
      step++;
      if (step == lat) begin
        inFlight = 1'b0;
        mDone    = 1'b1;
      end
    end else if (req_valid) begin
      mA = req_a;
      mB = req_b;
      mOp = req_op;
      if (!mOp) begin
        {expC, expRes} = {1'b0, mA} + {1'b0, mB};
        lowC  = ({1'b0, mA[7:0]} + {1'b0, mB[7:0]}) > 9'd255;
        hiRaw = mA[15:8] + mB[15:8];
      end else begin
        expRes = mA - mB;
        expC   = mA < mB;
        lowC   = mA[7:0] < mB[7:0];
        hiRaw  = mA[15:8] - mB[15:8];
      end
      expZ     = (expRes == 16'h0000);
      lat      = lowC ? 4 : 3;
      step     = 1;
      inFlight = 1'b1;
    end
  end

  logic [7:0] expOp1, expOp2;
  logic [4:0] expOpc;

  always @(negedge clk) begin
    if (modelOn) begin
      expOp1 = 8'h00;
      expOp2 = 8'h00;
      expOpc = OP_NOP;
      if (inFlight) begin
        expOpc = mOp ? OP_SUB : OP_ADD;
        if (step == 1) begin
          expOp1 = mA[7:0];
          expOp2 = mB[7:0];
        end else if (step == 2) begin
          expOp1 = mA[15:8];
          expOp2 = mB[15:8];
        end else begin
          expOp1 = hiRaw;
          expOp2 = 8'h01;
        end
      end
      checkOutput("req_ready", 16'(req_ready), 16'(!inFlight && !mDone));
      checkOutput("busy", 16'(busy), 16'(inFlight || mDone));
      checkOutput("rsp_valid", 16'(rsp_valid), 16'(mDone));
      checkOutput("alu_opcode", 16'(alu_opcode), 16'(expOpc));
      checkOutput("alu_operand1", 16'(alu_operand1), 16'(expOp1));
      checkOutput("alu_operand2", 16'(alu_operand2), 16'(expOp2));
      if (mDone) begin
        checkOutput("rsp_result", rsp_result, expRes);
        checkOutput("rsp_zero", 16'(rsp_zero), 16'(expZ));
        checkOutput("rsp_carry", 16'(rsp_carry), 16'(expC));
      end
    end
  end

  // Issue one request; inputs are scrambled once accepted, and the response may be stalled.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic op,
                               input int holdCycles, input logic [15:0] wantRes,
                               input logic wantZ, input logic wantC, input int wantLat);
    int edges;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = (holdCycles == 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_a     = ~a;
    req_b     = ~b;
    req_op    = ~op;
    req_valid = (holdCycles > 0);
    while (!rsp_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("latency", 16'(edges), 16'(wantLat));
    checkOutput("vec_result", rsp_result, wantRes);
    checkOutput("vec_zero", 16'(rsp_zero), 16'(wantZ));
    checkOutput("vec_carry", 16'(rsp_carry), 16'(wantC));
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_ready", 16'(req_ready), 16'h0000);
      checkOutput("hold_valid", 16'(rsp_valid), 16'h0001);
      checkOutput("hold_result", rsp_result, wantRes);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("back_idle", 16'(req_ready), 16'h0001);
    checkOutput("back_idle_valid", 16'(rsp_valid), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'h0001;
    req_b     = 16'h0001;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    checkOutput("rst_req_ready", 16'(req_ready), 16'h0001);
    checkOutput("rst_busy", 16'(busy), 16'h0000);
    checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
    checkOutput("rst_rsp_result", rsp_result, 16'h0000);
    checkOutput("rst_rsp_zero", 16'(rsp_zero), 16'h0000);
    checkOutput("rst_rsp_carry", 16'(rsp_carry), 16'h0000);
    checkOutput("rst_opcode", 16'(alu_opcode), 16'(OP_NOP));
    @(negedge clk);
    checkOutput("no_accept_in_rst", 16'(busy), 16'h0000);

    applyStimulus(16'h1234, 16'h1111, 1'b0, 0, 16'h2345, 1'b0, 1'b0, 3);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 4);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 4);
    applyStimulus(16'h0000, 16'h0001, 1'b1, 0, 16'hFFFF, 1'b0, 1'b1, 4);
    applyStimulus(16'h1000, 16'h0001, 1'b1, 0, 16'h0FFF, 1'b0, 1'b0, 4);
    applyStimulus(16'h5555, 16'h5555, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 3);
    applyStimulus(16'hFF00, 16'h00FF, 1'b1, 0, 16'hFE01, 1'b0, 1'b0, 4);
    applyStimulus(16'h8001, 16'h8000, 1'b0, 5, 16'h0001, 1'b0, 1'b1, 3);

    // Reset while the high-byte pass is in progress.
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'h1234;
    req_b     = 16'h4321;
    req_op    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hi_opnd1", 16'(alu_operand1), 16'h0012);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 16'(busy), 16'h0000);
    checkOutput("mid_rst_valid", 16'(rsp_valid), 16'h0000);
    checkOutput("mid_rst_opcode", 16'(alu_opcode), 16'(OP_NOP));
    checkOutput("mid_rst_ready", 16'(req_ready), 16'h0001);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 3);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 Parameter OP_ADD, default 5'b01000, ALU opcode driven for add passes.
REQ-002 Parameter OP_SUB, default 5'b01001, ALU opcode driven for subtract passes.
REQ-003 Parameter OP_NOP, default 5'b00000, ALU opcode driven when no pass is active.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_op  input  1  0 = 16-bit add, 1 = 16-bit subtract.
REQ-009 req_a  input  16  minuend/augend.
REQ-010 req_b  input  16  subtrahend/addend.
REQ-011 alu_operand1  output  8  to 8-bit ALU operand1.
REQ-012 alu_operand2  output  8  to 8-bit ALU operand2.
REQ-013 alu_opcode  output  5  to 8-bit ALU opcode.
REQ-014 alu_result  input  8  combinational result from 8-bit ALU, same cycle.
REQ-015 rsp_valid  output  1  response present.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_result  output  16  16-bit result.
REQ-018 rsp_zero  output  1  rsp_result == 16'h0000.
REQ-019 rsp_carry  output  1  add: carry out of bit 15; sub: borrow out of bit 15.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The block SHALL implement states IDLE, LO, HI, FIX, DONE.
REQ-022 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid && req_ready, latching req_a, req_b, req_op and moving to LO.
REQ-023 In LO the block SHALL drive a[7:0], b[7:0], opcode per op; at the edge capture alu_result as lo byte and c0, then go to HI.
REQ-024 In HI it SHALL drive a[15:8], b[15:8], same opcode; at the edge capture hi byte and c1; go to FIX if c0 = 1, else DONE.
REQ-025 In FIX it SHALL drive captured hi byte and 8'h01, same opcode; at the edge replace hi with alu_result, capture c2, go to DONE.
REQ-026 Carry/borrow SHALL be derived inside the block, never from ALU flags: add pass carry = (alu_result < operand1); sub pass borrow = (operand1 < operand2), unsigned 8-bit compares.
REQ-027 rsp_carry SHALL equal c1 | c2 (c2 = 0 when FIX skipped); rsp_zero SHALL equal ({hi,lo} == 0) after final pass.
REQ-028 rsp_valid SHALL be 1 only in DONE; rsp_result, rsp_zero, rsp_carry SHALL hold stable while rsp_valid && !rsp_ready.
REQ-029 In DONE with rsp_ready = 1 the block SHALL return to IDLE on that edge; req_ready SHALL not assert in the same cycle (no same-cycle turnaround).
REQ-030 Latency: rsp_valid SHALL assert 3 cycles after the accepting edge without FIX, 4 cycles with FIX.
REQ-031 In IDLE and DONE the block SHALL drive alu_opcode = OP_NOP and both ALU operands = 8'h00.
REQ-032 req_valid, req_a, req_b, req_op changes outside IDLE SHALL have no effect.

Reset
REQ-033 While rst = 1 at an edge the block SHALL enter IDLE from any state, discarding any in-flight operation.
REQ-034 Reset values: req_ready 1 (after reset), rsp_valid 0, busy 0, rsp_result 16'h0000, rsp_zero 0, rsp_carry 0, alu_opcode OP_NOP, alu operands 8'h00.
REQ-035 A request presented during the rst cycle SHALL not be accepted.

Verification
REQ-036 Add 16'h1234 + 16'h1111, rsp_ready = 1 -> rsp_result 16'h2345, Z 0, C 0, rsp_valid 3 cycles after accept, FIX not visited.
REQ-037 Add 16'h00FF + 16'h0001 -> 16'h0100, Z 0, C 0, FIX visited (alu_opcode OP_ADD, operand2 8'h01), rsp_valid after 4 cycles.
REQ-038 Add 16'hFFFF + 16'h0001 -> 16'h0000, Z 1, C 1; sub 16'h0000 - 16'h0001 -> 16'hFFFF, Z 0, C 1.
REQ-039 Sub 16'h1000 - 16'h0001 -> 16'h0FFF, Z 0, C 0, FIX visited; sub 16'h5555 - 16'h5555 -> 16'h0000, Z 1, C 0.
REQ-040 Hold rsp_ready = 0 for 5 cycles in DONE with req_valid = 1 -> outputs stable, req_ready 0, no second accept; rsp_ready = 1 -> IDLE next edge.
REQ-041 Assert rst for 1 cycle while in HI -> next cycle IDLE, rsp_valid 0, busy 0, alu_opcode OP_NOP; subsequent 16'h0001 + 16'h0001 -> 16'h0002.
